// File: rtl/dram_axi_pkg.sv
// dram_axi_pkg: AXI3 constants, channel state encoding and burst sizing shared
// by the DRAM reader and writer.
package dram_axi_pkg;

  localparam logic [1:0] SIZE_8B    = 2'b11;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // Every beat moves one 64-bit word.
  localparam int unsigned BEAT_BYTES = 8;

  // Each AXI channel engine is either waiting for a config or working through it.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;

  // Bytes covered by one burst of 2^log2_beats beats.
  function automatic logic [31:0] burst_bytes(input int unsigned log2_beats);
    return 32'(BEAT_BYTES) << log2_beats;
  endfunction

endpackage

// File: rtl/dram_writer_if.sv
// dram_writer_if: AXI3 write channels, config handshake and input stream of the
// DRAM writer. DRAM_WRITER_ERRFLAG_EN adds the ERR_FLAG / ERR_COUNT status.
interface dram_writer_if;

  logic [31:0] M_AXI_AWADDR;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [3:0]  M_AXI_AWLEN;
  logic [1:0]  M_AXI_AWSIZE;
  logic [1:0]  M_AXI_AWBURST;
  logic [63:0] M_AXI_WDATA;
  logic [7:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic        M_AXI_WLAST;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        CONFIG_VALID;
  logic        CONFIG_READY;
  logic [31:0] CONFIG_START_ADDR;
  logic [31:0] CONFIG_NBYTES;
  logic        din_valid;
  logic        din_ready;
  logic [63:0] din;
`ifdef DRAM_WRITER_ERRFLAG_EN
  logic        ERR_FLAG;
  logic [15:0] ERR_COUNT;
`endif

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, M_AXI_WLAST, M_AXI_BREADY,
    output CONFIG_READY, din_ready,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BRESP,
    input  CONFIG_VALID, CONFIG_START_ADDR, CONFIG_NBYTES, din_valid, din
`ifdef DRAM_WRITER_ERRFLAG_EN
    , output ERR_FLAG, ERR_COUNT
`endif
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, M_AXI_WLAST, M_AXI_BREADY,
    input  CONFIG_READY, din_ready,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BRESP,
    output CONFIG_VALID, CONFIG_START_ADDR, CONFIG_NBYTES, din_valid, din
`ifdef DRAM_WRITER_ERRFLAG_EN
    , input ERR_FLAG, ERR_COUNT
`endif
  );

endinterface

// File: rtl/dram_burst_counter.sv
// dram_burst_counter: 32-bit burst countdown with load, decrement and a flag
// marking the final outstanding burst.
module dram_burst_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        dec,
  output logic        last
);

  logic [31:0] cnt_q, cnt_d;

  // A fresh load takes priority; otherwise count down one burst per completion.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec) begin
      cnt_d = cnt_q - 32'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == 32'd1);

endmodule

// File: rtl/dram_writer.sv
// dram_writer: AXI3 write master turning a 64-bit valid/ready stream into
// fixed-length INCR bursts. AW, W and B run as independent engines that all
// start from one config handshake. Optional macro DRAM_WRITER_ERRFLAG_EN adds a
// sticky error flag and a saturating count of non-OKAY write responses.
import dram_axi_pkg::*;

module dram_writer #(
  parameter int unsigned LOG2_BEATS = 4
) (
  input logic           ACLK,
  input logic           rst_n,
  dram_writer_if.master bus
);

  localparam int unsigned BEATS       = 1 << LOG2_BEATS;
  localparam logic [3:0]  LAST_BEAT   = 4'(BEATS - 1);
  localparam logic [31:0] BURST_BYTES = burst_bytes(LOG2_BEATS);

  run_state_t  aw_state_q, aw_state_d;
  run_state_t  w_state_q, w_state_d;
  run_state_t  b_state_q, b_state_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [3:0]  beat_q, beat_d;
  logic [31:0] nb;
  logic        cfg_ready, cfg_fire, nb_nonzero;
  logic        aw_fire, w_fire, w_wrap, b_fire;
  logic        aw_last, w_last, b_last;

  assign cfg_ready  = (aw_state_q == ST_IDLE) && (w_state_q == ST_IDLE) && (b_state_q == ST_IDLE);
  assign cfg_fire   = bus.CONFIG_VALID && cfg_ready;
  assign nb         = bus.CONFIG_NBYTES >> (LOG2_BEATS + 3);
  assign nb_nonzero = (nb != 32'd0);
  assign aw_fire    = (aw_state_q == ST_RUN) && bus.M_AXI_AWREADY;
  assign w_fire     = (w_state_q == ST_RUN) && bus.din_valid && bus.M_AXI_WREADY;
  assign w_wrap     = w_fire && (beat_q == LAST_BEAT);
  assign b_fire     = (b_state_q == ST_RUN) && bus.M_AXI_BVALID;

  dram_burst_counter u_aw_cnt (
    .clk(ACLK), .rst_n(rst_n), .load(cfg_fire), .load_val(nb), .dec(aw_fire), .last(aw_last)
  );
  dram_burst_counter u_w_cnt (
    .clk(ACLK), .rst_n(rst_n), .load(cfg_fire), .load_val(nb), .dec(w_wrap), .last(w_last)
  );
  dram_burst_counter u_b_cnt (
    .clk(ACLK), .rst_n(rst_n), .load(cfg_fire), .load_val(nb), .dec(b_fire), .last(b_last)
  );

  // AW engine: issue one address per burst, stepping by the burst size.
  always_comb begin
    aw_state_d = aw_state_q;
    awaddr_d   = awaddr_q;
    if (cfg_fire) begin
      awaddr_d = bus.CONFIG_START_ADDR;
      if (nb_nonzero) aw_state_d = ST_RUN;
    end else if (aw_fire) begin
      awaddr_d = awaddr_q + BURST_BYTES;
      if (aw_last) aw_state_d = ST_IDLE;
    end
  end

  // W engine: count beats within a burst; the final beat of the final burst ends it.
  always_comb begin
    w_state_d = w_state_q;
    beat_d    = beat_q;
    if (cfg_fire) begin
      beat_d = 4'd0;
      if (nb_nonzero) w_state_d = ST_RUN;
    end else if (w_fire) begin
      beat_d = w_wrap ? 4'd0 : beat_q + 4'd1;
      if (w_wrap && w_last) w_state_d = ST_IDLE;
    end
  end

  // B engine: accept one response per burst.
  always_comb begin
    b_state_d = b_state_q;
    if (cfg_fire) begin
      if (nb_nonzero) b_state_d = ST_RUN;
    end else if (b_fire && b_last) begin
      b_state_d = ST_IDLE;
    end
  end

  // State, address and beat registers.
  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      aw_state_q <= ST_IDLE;
      w_state_q  <= ST_IDLE;
      b_state_q  <= ST_IDLE;
      awaddr_q   <= '0;
      beat_q     <= '0;
    end else begin
      aw_state_q <= aw_state_d;
      w_state_q  <= w_state_d;
      b_state_q  <= b_state_d;
      awaddr_q   <= awaddr_d;
      beat_q     <= beat_d;
    end
  end

  assign bus.M_AXI_AWADDR  = awaddr_q;
  assign bus.M_AXI_AWVALID = (aw_state_q == ST_RUN);
  assign bus.M_AXI_AWLEN   = LAST_BEAT;
  assign bus.M_AXI_AWSIZE  = SIZE_8B;
  assign bus.M_AXI_AWBURST = BURST_INCR;
  assign bus.M_AXI_WDATA   = bus.din;
  assign bus.M_AXI_WSTRB   = 8'hFF;
  assign bus.M_AXI_WVALID  = (w_state_q == ST_RUN) && bus.din_valid;
  assign bus.M_AXI_WLAST   = (beat_q == LAST_BEAT);
  assign bus.din_ready     = (w_state_q == ST_RUN) && bus.M_AXI_WREADY;
  assign bus.M_AXI_BREADY  = (b_state_q == ST_RUN);
  assign bus.CONFIG_READY  = cfg_ready;

`ifdef DRAM_WRITER_ERRFLAG_EN
  logic        err_flag_q, err_flag_d;
  logic [15:0] err_count_q, err_count_d;
  logic        bad_resp;

  assign bad_resp = b_fire && (bus.M_AXI_BRESP != RESP_OKAY);

  // Sticky flag and saturating count of bad responses, cleared by a new config.
  always_comb begin
    err_flag_d  = err_flag_q;
    err_count_d = err_count_q;
    if (cfg_fire) begin
      err_flag_d  = 1'b0;
      err_count_d = '0;
    end else if (bad_resp) begin
      err_flag_d = 1'b1;
      if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
    end
  end

  // Error status registers.
  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.ERR_FLAG  = err_flag_q;
  assign bus.ERR_COUNT = err_count_q;
`else
  logic bresp_unused;
  assign bresp_unused = ^bus.M_AXI_BRESP;
`endif

endmodule

// File: tb/tb_dram_writer.sv
// tb_dram_writer: randomized bench for dram_writer with a responsive AXI slave
// model and a queue-based reference of expected addresses, data and WLAST.
`timescale 1ns/1ps
module tb_dram_writer;

  localparam int unsigned L      = 4;
  localparam int unsigned BEATS  = 1 << L;
  localparam int unsigned BBYTES = BEATS * 8;

  logic ACLK = 1'b0;
  logic rst_n = 1'b0;

  dram_writer_if bus ();

  dram_writer #(.LOG2_BEATS(L)) dut (
    .ACLK (ACLK),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 ACLK = ~ACLK;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // slave / source knobs
  int aw_pct = 100, w_pct = 100, v_pct = 100, b_pct = 100;
  int aw_hold = 0;
  int err_burst = -1;

  // source data and captured traffic
  logic [63:0] src_mem [0:255];
  int          src_idx = 0;
  logic [31:0] aw_q[$];
  logic [63:0] wd_q[$];
  logic        wl_q[$];
  int          wlast_n = 0, b_sent = 0;
  int          aw_first_cyc = -1, w_done_cyc = -1;
  int          aw_unstable = 0, const_bad = 0;
  logic        aw_pend = 1'b0;
  logic [31:0] aw_hold_addr = '0;

  initial forever begin
    @(posedge ACLK);
    cyc++;
  end

  // Slave and source drivers: update all DUT inputs just after each rising edge.
  initial begin
    int owed;
    bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0; bus.M_AXI_BVALID = 1'b0;
    bus.M_AXI_BRESP = 2'b00; bus.CONFIG_VALID = 1'b0; bus.CONFIG_START_ADDR = '0;
    bus.CONFIG_NBYTES = '0; bus.din_valid = 1'b0; bus.din = '0;
    forever begin
      @(posedge ACLK);
      #1;
      bus.M_AXI_AWREADY = (aw_hold > 0) ? 1'b0 : ($urandom_range(99) < aw_pct);
      if (aw_hold > 0) aw_hold--;
      bus.M_AXI_WREADY = ($urandom_range(99) < w_pct);
      bus.din_valid = ($urandom_range(99) < v_pct);
      bus.din = src_mem[src_idx[7:0]];
      owed = ((aw_q.size() < wlast_n) ? aw_q.size() : wlast_n) - b_sent;
      bus.M_AXI_BVALID = (owed > 0) && ($urandom_range(99) < b_pct);
      bus.M_AXI_BRESP = (b_sent == err_burst) ? 2'b10 : 2'b00;
    end
  end

  // Monitor: record handshakes mid-cycle, ahead of the edge that completes them.
  initial forever begin
    @(negedge ACLK);
    if (!rst_n) begin
      aw_pend = 1'b0; wlast_n = 0; b_sent = 0;
    end else begin
      if (bus.M_AXI_AWVALID) begin
        if (aw_pend && bus.M_AXI_AWADDR !== aw_hold_addr) aw_unstable++;
        if (bus.M_AXI_AWLEN !== 4'(BEATS - 1) || bus.M_AXI_AWSIZE !== 2'b11 || bus.M_AXI_AWBURST !== 2'b01)
          const_bad++;
        if (bus.M_AXI_AWREADY) begin
          aw_q.push_back(bus.M_AXI_AWADDR);
          if (aw_q.size() == 1) aw_first_cyc = cyc;
          aw_pend = 1'b0;
        end else begin
          aw_pend = 1'b1;
          aw_hold_addr = bus.M_AXI_AWADDR;
        end
      end else begin
        aw_pend = 1'b0;
      end
      if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
        wd_q.push_back(bus.M_AXI_WDATA);
        wl_q.push_back(bus.M_AXI_WLAST);
        if (bus.M_AXI_WLAST) wlast_n++;
        if (bus.M_AXI_WSTRB !== 8'hFF) const_bad++;
        w_done_cyc = cyc;
      end
      if (bus.din_valid && bus.din_ready) src_idx++;
      if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) b_sent++;
    end
  end

  // Fresh source data, cleared capture, then one config handshake.
  task automatic do_config(input logic [31:0] addr, input logic [31:0] nbytes);
    aw_q.delete(); wd_q.delete(); wl_q.delete();
    wlast_n = 0; b_sent = 0; src_idx = 0; aw_unstable = 0; const_bad = 0;
    aw_first_cyc = -1; w_done_cyc = -1;
    for (int i = 0; i < 256; i++) src_mem[i] = {$urandom, $urandom};
    @(posedge ACLK); #1;
    bus.CONFIG_START_ADDR = addr;
    bus.CONFIG_NBYTES = nbytes;
    bus.CONFIG_VALID = 1'b1;
    @(posedge ACLK); #1;
    bus.CONFIG_VALID = 1'b0;
  endtask

  // One full transfer checked against the reference: address i = start + i*burst,
  // beat k carries the k-th offered word, WLAST on every BEATS-th beat.
  task automatic test_transfer(input string name, input logic [31:0] addr,
                               input logic [31:0] nbytes, input int budget);
    int nb, nbeats, waited, diffs, n;
    nb = int'(nbytes >> (L + 3));
    nbeats = nb * int'(BEATS);
    do_config(addr, nbytes);
    waited = 0;
    while (waited < budget) begin
      @(negedge ACLK);
      if (bus.CONFIG_READY) break;
      waited++;
    end
    tests_run++;
    if (waited >= budget) begin
      $display("FAIL %s timeout: CONFIG_READY=0 after %0d cycles, required 1", name, budget);
      tests_failed++;
      rst_n = 1'b0;
      repeat (2) @(negedge ACLK);
      rst_n = 1'b1;
      return;
    end
    tests_run++;
    if (b_sent != nb) begin
      $display("FAIL %s b_before_ready: got %0d responses, required %0d", name, b_sent, nb);
      tests_failed++;
    end
    repeat (3) @(negedge ACLK);
    $display("[TB] %s: addr=%08h bursts=%0d beats=%0d cycles=%0d", name, addr, aw_q.size(), wd_q.size(), waited);
    tests_run++;
    if (aw_q.size() != nb) begin
      $display("FAIL %s aw_count: got %0d, required %0d", name, aw_q.size(), nb);
      tests_failed++;
    end
    diffs = 0;
    n = (aw_q.size() < nb) ? aw_q.size() : nb;
    for (int i = 0; i < n; i++)
      if (aw_q[i] !== addr + 32'(i) * BBYTES) diffs++;
    tests_run++;
    if (diffs != 0) begin
      $display("FAIL %s aw_addr: %0d wrong addresses (first got %08h, required %08h)", name, diffs,
               (n > 0) ? aw_q[0] : 32'h0, addr);
      tests_failed++;
    end
    tests_run++;
    if (wd_q.size() != nbeats) begin
      $display("FAIL %s beat_count: got %0d, required %0d", name, wd_q.size(), nbeats);
      tests_failed++;
    end
    diffs = 0;
    n = (wd_q.size() < nbeats) ? wd_q.size() : nbeats;
    for (int k = 0; k < n; k++)
      if (wd_q[k] !== src_mem[k]) diffs++;
    tests_run++;
    if (diffs != 0) begin
      $display("FAIL %s data_order: %0d beats differ from stream order, required 0", name, diffs);
      tests_failed++;
    end
    diffs = 0;
    for (int k = 0; k < n; k++)
      if (wl_q[k] !== ((k % int'(BEATS)) == int'(BEATS) - 1)) diffs++;
    tests_run++;
    if (diffs != 0 || wlast_n != nb) begin
      $display("FAIL %s wlast: %0d misplaced, count %0d, required 0 misplaced and count %0d", name, diffs, wlast_n, nb);
      tests_failed++;
    end
    tests_run++;
    if (aw_unstable != 0 || const_bad != 0) begin
      $display("FAIL %s aw_stable_consts: unstable=%0d bad_const=%0d, required 0 and 0", name, aw_unstable, const_bad);
      tests_failed++;
    end
  endtask

  task automatic test_reset();
    #3;
    tests_run++;
    if ({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.din_ready, bus.CONFIG_READY} !== 5'b00001
        || bus.M_AXI_AWADDR !== 32'h0) begin
      $display("FAIL reset_state: aw/w/b/dr/cr=%b addr=%08h, required 00001 and 00000000",
               {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.din_ready, bus.CONFIG_READY},
               bus.M_AXI_AWADDR);
      tests_failed++;
    end
    repeat (3) @(negedge ACLK);
    rst_n = 1'b1;
    repeat (2) @(negedge ACLK);
  endtask

  task automatic test_basic();
    aw_pct = 100; w_pct = 100; v_pct = 100; b_pct = 100;
    test_transfer("basic", 32'h1000_0000, 32'd256, 200);
    tests_run++;
    if (aw_q.size() != 2 || aw_q[0] !== 32'h1000_0000 || aw_q[1] !== 32'h1000_0080) begin
      $display("FAIL basic_addrs: got %0d addresses, first %08h, required 10000000 then 10000080",
               aw_q.size(), (aw_q.size() > 0) ? aw_q[0] : 32'h0);
      tests_failed++;
    end
    tests_run++;
    if (wl_q.size() != 32 || wl_q[15] !== 1'b1 || wl_q[31] !== 1'b1 || wl_q[14] !== 1'b0) begin
      $display("FAIL basic_wlast: beats=%0d, required WLAST on beats 15 and 31 of 32", wl_q.size());
      tests_failed++;
    end
  endtask

  task automatic test_short();
    int busy;
    do_config(32'h1000_0000, 32'd100);
    busy = 0;
    repeat (20) begin
      @(negedge ACLK);
      if (bus.M_AXI_AWVALID || bus.M_AXI_WVALID || bus.M_AXI_BREADY || !bus.CONFIG_READY) busy++;
    end
    $display("[TB] short: nbytes=100 busy_cycles=%0d", busy);
    tests_run++;
    if (busy != 0 || aw_q.size() != 0 || wd_q.size() != 0) begin
      $display("FAIL short_idle: busy=%0d aw=%0d w=%0d, required 0 0 0", busy, aw_q.size(), wd_q.size());
      tests_failed++;
    end
  endtask

  task automatic test_random();
    aw_pct = 60; w_pct = 50; v_pct = 50; b_pct = 70;
    for (int it = 0; it < 4; it++) begin
      logic [31:0] a;
      a = $urandom & ~32'(BBYTES - 1);
      test_transfer("random", a, 32'($urandom_range(4, 1) * BBYTES + $urandom_range(BBYTES - 1)), 3000);
    end
    test_transfer("wrap", 32'hFFFF_FF80, 32'd300, 3000);
    aw_pct = 100; w_pct = 100; v_pct = 100; b_pct = 100;
  endtask

  task automatic test_aw_stall();
    aw_hold = 42;
    test_transfer("aw_stall", 32'h2000_0000, 32'd128, 300);
    tests_run++;
    if (!(w_done_cyc >= 0 && aw_first_cyc > w_done_cyc)) begin
      $display("FAIL aw_stall_order: last W cycle %0d, first AW cycle %0d, required W before AW", w_done_cyc, aw_first_cyc);
      tests_failed++;
    end
  endtask

  task automatic test_reset_mid();
    int waited;
    aw_hold = 30;
    do_config(32'h3000_0000, 32'd256);
    waited = 0;
    while (wd_q.size() < 7 && waited < 100) begin
      @(negedge ACLK);
      waited++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.din_ready, bus.CONFIG_READY, bus.M_AXI_WLAST} !== 6'b000010
        || bus.M_AXI_AWADDR !== 32'h0 || wd_q.size() != 7) begin
      $display("FAIL reset_mid: aw/w/b/dr/cr/wl=%b addr=%08h beats=%0d, required 000010 00000000 7",
               {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.din_ready, bus.CONFIG_READY, bus.M_AXI_WLAST},
               bus.M_AXI_AWADDR, wd_q.size());
      tests_failed++;
    end
    aw_hold = 0;
    repeat (3) @(negedge ACLK);
    #2;
    rst_n = 1'b1;
    test_transfer("after_reset", 32'h3000_1000, 32'd128, 200);
  endtask

`ifdef DRAM_WRITER_ERRFLAG_EN
  task automatic test_errflag();
    err_burst = 1;
    test_transfer("err", 32'h4000_0000, 32'd384, 300);
    tests_run++;
    if (bus.ERR_FLAG !== 1'b1 || bus.ERR_COUNT !== 16'd1) begin
      $display("FAIL err_set: flag=%b count=%0d, required 1 and 1", bus.ERR_FLAG, bus.ERR_COUNT);
      tests_failed++;
    end
    err_burst = -1;
    test_transfer("err_clear", 32'h4000_1000, 32'd128, 200);
    tests_run++;
    if (bus.ERR_FLAG !== 1'b0 || bus.ERR_COUNT !== 16'd0) begin
      $display("FAIL err_clear: flag=%b count=%0d, required 0 and 0", bus.ERR_FLAG, bus.ERR_COUNT);
      tests_failed++;
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) src_mem[i] = '0;
    test_reset();
    test_basic();
    test_short();
    test_random();
    test_aw_stall();
    test_reset_mid();
`ifdef DRAM_WRITER_ERRFLAG_EN
    test_errflag();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
